// File: rtl/intctrl.sv
// intctrl: collects level-sensitive device interrupt requests and presents
// them one at a time to the CPU over intrqst_o/intrdy_i. Once software has
// serviced the source (CMDACKINT), the device is released with a one-cycle
// low pulse on its intrdysrc_o line, then a short drain lets it drop its
// request before arbitration resumes.
// Optional build macro: INTCTRL_FIXEDPRIO_EN selects fixed lowest-index
// priority instead of round-robin and removes the rotating pointer.
module intctrl #(
  parameter int ARCHBITSZ   = 32,
  parameter int INTSRCCOUNT = 8,
  localparam int ADDRBITSZ  = ARCHBITSZ - $clog2(ARCHBITSZ/8)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [1:0]               pi1_op_i,
  input  logic [ADDRBITSZ-1:0]     pi1_addr_i,
  input  logic [ARCHBITSZ-1:0]     pi1_data_i,
  output logic [ARCHBITSZ-1:0]     pi1_data_o,
  input  logic [ARCHBITSZ/8-1:0]   pi1_sel_i,
  output logic                     pi1_rdy_o,
  output logic [ADDRBITSZ-1:0]     pi1_mapsz_o,
  output logic                     intrqst_o,
  input  logic                     intrdy_i,
  input  logic [INTSRCCOUNT-1:0]   intrqstsrc_i,
  output logic [INTSRCCOUNT-1:0]   intrdysrc_o
);

  localparam int IW = (INTSRCCOUNT > 1) ? $clog2(INTSRCCOUNT) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVICE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [INTSRCCOUNT-1:0]   en_q, en_d;
  logic [INTSRCCOUNT-1:0]   rdysrc_q, rdysrc_d;
  logic [IW-1:0]            srcidx_q, srcidx_d;
  logic                     rqst_q, rqst_d;
  logic [ARCHBITSZ-1:0]     data_q, data_d;
  logic [1:0]               drain_q, drain_d;
`ifndef INTCTRL_FIXEDPRIO_EN
  logic [IW-1:0]            ptr_q, ptr_d;
`endif

  logic [INTSRCCOUNT-1:0]   active;
  logic [IW-1:0]            sel;
  logic                     is_rw;
  logic                     cmd_ack;
  logic [ARCHBITSZ-1:0]     rd_word;
  logic                     unused_ok;

  assign active    = intrqstsrc_i & en_q;
  assign is_rw     = (pi1_op_i == 2'b11);
  assign cmd_ack   = is_rw & ~pi1_data_i[ARCHBITSZ-1];

  assign pi1_rdy_o   = 1'b1;
  assign pi1_mapsz_o = ADDRBITSZ'((ARCHBITSZ < 64) ? (64 / ARCHBITSZ) : 1);
  assign pi1_data_o  = data_q;
  assign intrqst_o   = rqst_q;
  assign intrdysrc_o = rdysrc_q;

  // Address, byte selects and high argument bits carry no meaning here.
  assign unused_ok = ^{pi1_addr_i, pi1_sel_i, pi1_data_i};

  // Pick the winning source: scan downward so the lowest offset wins last.
  always_comb begin
    logic [IW-1:0] cand;
    int            idx;
    sel  = '0;
    cand = '0;
    idx  = 0;
    for (int i = INTSRCCOUNT - 1; i >= 0; i--) begin
`ifdef INTCTRL_FIXEDPRIO_EN
      idx = i;
`else
      idx = int'(ptr_q) + i;
      if (idx >= INTSRCCOUNT) idx = idx - INTSRCCOUNT;
`endif
      cand = IW'(idx);
      if (active[cand]) sel = cand;
    end
  end

  // Status word for RD: state in the top two bits, active sources at the bottom.
  always_comb begin
    rd_word = '0;
    rd_word[INTSRCCOUNT-1:0] = active;
    rd_word[ARCHBITSZ-1:ARCHBITSZ-2] = state_q;
  end

  // Next-state logic for the handshake FSM and the software port.
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    rdysrc_d = '1;
    srcidx_d = srcidx_q;
    rqst_d   = rqst_q;
    data_d   = data_q;
    drain_d  = drain_q;
`ifndef INTCTRL_FIXEDPRIO_EN
    ptr_d    = ptr_q;
`endif

    // Software port; the enable write takes effect after this cycle's arbitration.
    case (pi1_op_i)
      2'b10: data_d = rd_word;
      2'b11: begin
        if (pi1_data_i[ARCHBITSZ-1]) begin
          en_d   = pi1_data_i[INTSRCCOUNT-1:0];
          data_d = ARCHBITSZ'(INTSRCCOUNT);
        end else if (state_q == SERVICE) begin
          data_d = ARCHBITSZ'(srcidx_q);
        end else begin
          data_d = '1;
        end
      end
      default: ;
    endcase

    case (state_q)
      IDLE: begin
        if (|active) begin
          srcidx_d = sel;
          rqst_d   = 1'b1;
          state_d  = PENDING;
        end
      end
      PENDING: begin
        if (!intrdy_i) begin
          rqst_d  = 1'b0;
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (cmd_ack) begin
          rdysrc_d[srcidx_q] = 1'b0;
          drain_d            = 2'd0;
          state_d            = DRAIN;
        end
      end
      DRAIN: begin
        // First DRAIN cycle carries the release pulse; two more let the device settle.
        if (drain_q == 2'd2) begin
          state_d = IDLE;
`ifndef INTCTRL_FIXEDPRIO_EN
          ptr_d = (srcidx_q == IW'(INTSRCCOUNT - 1)) ? '0 : srcidx_q + IW'(1);
`endif
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset also cuts any release pulse short.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      en_q     <= '0;
      rdysrc_q <= '1;
      srcidx_q <= '0;
      rqst_q   <= 1'b0;
      data_q   <= '0;
      drain_q  <= 2'd0;
`ifndef INTCTRL_FIXEDPRIO_EN
      ptr_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      rdysrc_q <= rdysrc_d;
      srcidx_q <= srcidx_d;
      rqst_q   <= rqst_d;
      data_q   <= data_d;
      drain_q  <= drain_d;
`ifndef INTCTRL_FIXEDPRIO_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_intctrl.sv
// Bench for intctrl: a transaction-level model tracks the expected CPU
// request, device release lines and read data; a compare process checks the
// DUT against it every cycle, and directed sequences pin literal values.
module tb_intctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  op = 2'b00;
  logic [29:0] addr = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic [3:0]  sel = '0;
  logic        rdy;
  logic [29:0] mapsz;
  logic        intrqst;
  logic        intrdy = 1'b1;
  logic [7:0]  src = '0;
  logic [7:0]  rdysrc;

  int total = 0;
  int passed = 0;
  bit running = 1'b1;

  intctrl #(.ARCHBITSZ(32), .INTSRCCOUNT(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .pi1_op_i(op), .pi1_addr_i(addr), .pi1_data_i(data_i), .pi1_data_o(data_o),
    .pi1_sel_i(sel), .pi1_rdy_o(rdy), .pi1_mapsz_o(mapsz),
    .intrqst_o(intrqst), .intrdy_i(intrdy),
    .intrqstsrc_i(src), .intrdysrc_o(rdysrc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  // ---------------- model ----------------
  int          cyc = 0;
  int          m_state = 0;       // 0 idle, 1 pending, 2 service, 3 drain
  logic [7:0]  m_en = '0;
  logic [7:0]  m_rdysrc = 8'hFF;
  logic        m_req = 1'b0;
  logic [31:0] m_data = '0;
  int          m_idx = 0;
  int          m_ptr = 0;
  int          m_drain_end = 0;
  logic [7:0]  m_act;
  logic [7:0]  m_en_next;
  int          m_pick;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_en = '0; m_rdysrc = 8'hFF; m_req = 1'b0;
      m_data = '0; m_idx = 0; m_ptr = 0;
    end else begin
      cyc++;
      m_act = src & m_en;
      m_en_next = m_en;
      m_rdysrc = 8'hFF;
      if (op == 2'b10) m_data = (32'(m_state) << 30) | {24'b0, m_act};
      else if (op == 2'b11) begin
        if (data_i[31]) begin
          m_data = 32'd8;
          m_en_next = data_i[7:0];
        end else m_data = (m_state == 2) ? 32'(m_idx) : 32'hFFFF_FFFF;
      end
      case (m_state)
        0: if (m_act != 0) begin
          m_pick = -1;
          for (int i = 0; i < 8; i++) begin
`ifdef INTCTRL_FIXEDPRIO_EN
            if (m_pick < 0 && m_act[i]) m_pick = i;
`else
            if (m_pick < 0 && m_act[(m_ptr + i) % 8]) m_pick = (m_ptr + i) % 8;
`endif
          end
          m_idx = m_pick; m_req = 1'b1; m_state = 1;
        end
        1: if (!intrdy) begin m_req = 1'b0; m_state = 2; end
        2: if (op == 2'b11 && !data_i[31]) begin
          m_rdysrc[m_idx] = 1'b0; m_state = 3; m_drain_end = cyc + 3;
        end
        default: if (cyc == m_drain_end) begin
          m_state = 0; m_ptr = (m_idx + 1) % 8;
        end
      endcase
      m_en = m_en_next;
    end
  end

  // Compare DUT against model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (running) begin
      chk("intrqst_o", 32'(intrqst), 32'(m_req));
      chk("intrdysrc_o", 32'(rdysrc), 32'(m_rdysrc));
      chk("pi1_data_o", data_o, m_data);
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] d, output logic [31:0] r);
    op = o; data_i = d;
    @(negedge clk);
    r = data_o;
    op = 2'b00; data_i = '0;
  endtask

  task automatic cpu_ack();
    intrdy = 1'b0;
    @(negedge clk);
    intrdy = 1'b1;
  endtask

  task automatic wait_req();
    int t = 0;
    while (intrqst !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("req_wait", 32'(intrqst), 32'd1);
  endtask

  logic [31:0] r;
  logic [31:0] rr_exp [4];

  initial begin
`ifdef INTCTRL_FIXEDPRIO_EN
    rr_exp = '{32'd1, 32'd1, 32'd1, 32'd1};
`else
    rr_exp = '{32'd1, 32'd3, 32'd6, 32'd1};
`endif
    idle(2);
    chk("rst_intrqst", 32'(intrqst), 32'd0);
    chk("rst_intrdysrc", 32'(rdysrc), 32'hFF);
    chk("rst_data", data_o, 32'd0);
    rst = 1'b0;
    chk("pi1_rdy", 32'(rdy), 32'd1);
    chk("pi1_mapsz", 32'(mapsz), 32'd2);

    // disabled source, plus intrdy low outside PENDING
    src = 8'h10; intrdy = 1'b0; idle(1); intrdy = 1'b1; idle(2);
    chk("disabled_noreq", 32'(intrqst), 32'd0);
    do_op(2'b10, 32'd0, r);
    chk("disabled_rd", r, 32'd0);

    // enable readback; RD in the enable-following cycle still sees IDLE
    src = 8'hFF;
    do_op(2'b11, 32'h8000_0081, r);
    chk("enable_ret", r, 32'd8);
    do_op(2'b10, 32'd0, r);
    chk("enable_rd_active", r, 32'h0000_0081);
    chk("enable_req", 32'(intrqst), 32'd1);

    // out-of-state ack in PENDING
    do_op(2'b11, 32'd0, r);
    chk("ack_pending_ret", r, 32'hFFFF_FFFF);
    chk("ack_pending_nopulse", 32'(rdysrc), 32'hFF);
    cpu_ack();
    chk("cpu_ack_drop", 32'(intrqst), 32'd0);
    do_op(2'b11, 32'd0, r);
    chk("ack_src0", r, 32'd0);
    chk("pulse_src0", 32'(rdysrc), 32'hFE);
    src = 8'h00;
    idle(3);
    do_op(2'b11, 32'd0, r);
    chk("ack_idle_ret", r, 32'hFFFF_FFFF);
    chk("ack_idle_nopulse", 32'(rdysrc), 32'hFF);

    // single source
    do_op(2'b11, 32'h8000_0004, r);
    src = 8'h04;
    chk("single_pre", 32'(intrqst), 32'd0);
    idle(1);
    chk("single_latency", 32'(intrqst), 32'd1);
    cpu_ack();
    chk("single_cpu_ack", 32'(intrqst), 32'd0);
    do_op(2'b11, 32'd0, r);
    chk("single_ack_ret", r, 32'd2);
    chk("single_pulse", 32'(rdysrc), 32'hFB);
    src = 8'h00;
    do_op(2'b10, 32'd0, r);
    chk("drain_rd0", r, 32'hC000_0000);
    chk("single_pulse_end", 32'(rdysrc), 32'hFF);
    do_op(2'b10, 32'd0, r);
    chk("drain_rd1", r, 32'hC000_0000);
    do_op(2'b10, 32'd0, r);
    chk("drain_rd2", r, 32'hC000_0000);
    do_op(2'b10, 32'd0, r);
    chk("idle_after_drain", r, 32'd0);

    // reset in the middle of a release pulse
    do_op(2'b11, 32'h8000_0002, r);
    src = 8'h02;
    wait_req();
    cpu_ack();
    do_op(2'b11, 32'd0, r);
    chk("mid_ack_ret", r, 32'd1);
    chk("mid_pulse", 32'(rdysrc), 32'hFD);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_intrqst", 32'(intrqst), 32'd0);
    chk("async_rst_intrdysrc", 32'(rdysrc), 32'hFF);
    chk("async_rst_data", data_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    chk("post_rst_disabled", 32'(intrqst), 32'd0);
    src = 8'h00;

    // round-robin (or fixed priority) over sources 1, 3, 6
    src = 8'h4A;
    do_op(2'b11, 32'h8000_00FF, r);
    chk("rr_enable_ret", r, 32'd8);
    for (int n = 0; n < 4; n++) begin
      wait_req();
      cpu_ack();
      do_op(2'b11, 32'd0, r);
      chk($sformatf("rr_ack%0d", n), r, rr_exp[n]);
      idle(3);
    end
    src = 8'h00;
    idle(2);

    running = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
